// File: rtl/sn74123_pkg.sv
// sn74123_pkg
//   Shared types for the SN74123 one-shot model.
//   pulse_state_e is one-hot so that q and q_n each come straight
//   off their own flop: bit 1 is q, bit 0 is q_n.
package sn74123_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_PULSE = 2'b10
  } pulse_state_e;

endpackage : sn74123_pkg

// File: rtl/sn74123_if.sv
// sn74123_if
//   Pin bundle for one SN74123 section.
//   master : drives the trigger pins (a_n, b, clr_n), reads q / q_n
//   slave  : the one-shot itself; reads triggers, drives q / q_n
interface sn74123_if;
  logic a_n;
  logic b;
  logic clr_n;
  logic q;
  logic q_n;

  modport master (output a_n, output b, output clr_n, input q, input q_n);
  modport slave  (input a_n, input b, input clr_n, output q, output q_n);
endinterface : sn74123_if

// File: rtl/ttl_edge_det.sv
// ttl_edge_det
//   One-bit "previous value" register with rise/fall flags, used by the
//   TTL models to turn mclk-sampled pin levels into edge events.
//   Ports:
//     clk  : master clock
//     rst  : synchronous active-high reset
//     d    : current pin level
//     old  : level of d registered on the previous clk edge
//     rise : d is 1 now and was 0 on the previous edge
//     fall : d is 0 now and was 1 on the previous edge
module ttl_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic old,
  output logic rise,
  output logic fall
);

  // During reset the history is loaded with the live pin value rather than
  // a constant, so a pin already sitting at its active level when reset
  // drops is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      old <= d;
    end else begin
      old <= d;
    end
  end

  assign rise = d & ~old;
  assign fall = ~d & old;

endmodule : ttl_edge_det

// File: rtl/sn74123.sv
// sn74123
//   One section of an SN74123 retriggerable monostable, sampled entirely
//   on mclk. The RC width is expressed as PULSE_CYCLES mclk cycles.
//   RETRIG=1 gives 74123 behaviour (retrigger restarts the width),
//   RETRIG=0 gives 74121-style behaviour (triggers ignored mid-pulse).
//   Ports:
//     mclk : master clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : sn74123_if.slave -- a_n, b, clr_n in; registered q, q_n out
module sn74123
  import sn74123_pkg::*;
#(
  parameter int PULSE_CYCLES = 5,
  parameter int RETRIG       = 1
) (
  input  logic        mclk,
  input  logic        rst,
  sn74123_if.slave    bus
);

  generate
    if (PULSE_CYCLES < 1) begin : g_bad_width
      $error("sn74123: PULSE_CYCLES must be at least 1");
    end
  endgenerate

  localparam int CNT_W = (PULSE_CYCLES < 1) ? 1 : $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

  pulse_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic a_old, a_rise, a_fall;
  logic b_old, b_rise, b_fall;
  logic c_old, c_rise, c_fall;
  logic trig;
  logic accept;

  ttl_edge_det u_det_a (.clk(mclk), .rst(rst), .d(bus.a_n),
                        .old(a_old), .rise(a_rise), .fall(a_fall));
  ttl_edge_det u_det_b (.clk(mclk), .rst(rst), .d(bus.b),
                        .old(b_old), .rise(b_rise), .fall(b_fall));
  ttl_edge_det u_det_c (.clk(mclk), .rst(rst), .d(bus.clr_n),
                        .old(c_old), .rise(c_rise), .fall(c_fall));

  // Every trigger form needs the other two pins at their enabling level,
  // so several simultaneous forms collapse into a single trigger.
  assign trig = (a_fall & bus.b & bus.clr_n)
              | (b_rise & ~bus.a_n & bus.clr_n)
              | (c_rise & ~bus.a_n & bus.b);

  // A trigger landing on the expiry edge (cnt already 0) is always taken,
  // even when not retriggerable, so back-to-back pulses stay seamless.
  assign accept = trig && ((state == ST_IDLE) || (RETRIG != 0) || (cnt == '0));

  // State register: reset kills any pulse in progress on that edge.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: clear dominates, then trigger, then count-down / expiry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!bus.clr_n) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (accept) begin
      state_nxt = ST_PULSE;
      cnt_nxt   = CNT_LOAD;
    end else if (state == ST_PULSE) begin
      if (cnt != '0) begin
        cnt_nxt = cnt - CNT_W'(1);
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  // Outputs are the one-hot state flops themselves, so q and q_n are
  // registered, always complementary, and have no path from the inputs.
  always_comb begin
    bus.q   = state[1];
    bus.q_n = state[0];
  end

endmodule : sn74123

// File: tb/tb_sn74123.sv
// tb_sn74123
//   Self-checking bench for sn74123. Four sections share one set of pins:
//   index 0: PULSE_CYCLES=5 RETRIG=1   index 1: PULSE_CYCLES=5 RETRIG=0
//   index 2: PULSE_CYCLES=1 RETRIG=1   index 3: PULSE_CYCLES=1 RETRIG=0
module tb_sn74123;

  localparam int P_TAB[4] = '{5, 5, 1, 1};
  localparam int R_TAB[4] = '{1, 0, 1, 0};

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  logic a_n  = 1'b1;
  logic b    = 1'b0;
  logic clr_n = 1'b1;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  // Reference model: each section remembers the edge number after which
  // its pulse ends; q after edge t is simply (t < end_edge).
  int tick = 0;
  int end_edge[4] = '{0, 0, 0, 0};
  logic prev_a = 1'b1, prev_b = 1'b0, prev_c = 1'b1;

  sn74123_if bus51 ();
  sn74123_if bus50 ();
  sn74123_if bus11 ();
  sn74123_if bus10 ();

  assign bus51.a_n = a_n;  assign bus51.b = b;  assign bus51.clr_n = clr_n;
  assign bus50.a_n = a_n;  assign bus50.b = b;  assign bus50.clr_n = clr_n;
  assign bus11.a_n = a_n;  assign bus11.b = b;  assign bus11.clr_n = clr_n;
  assign bus10.a_n = a_n;  assign bus10.b = b;  assign bus10.clr_n = clr_n;

  sn74123 #(.PULSE_CYCLES(5), .RETRIG(1)) dut51 (.mclk(mclk), .rst(rst), .bus(bus51));
  sn74123 #(.PULSE_CYCLES(5), .RETRIG(0)) dut50 (.mclk(mclk), .rst(rst), .bus(bus50));
  sn74123 #(.PULSE_CYCLES(1), .RETRIG(1)) dut11 (.mclk(mclk), .rst(rst), .bus(bus11));
  sn74123 #(.PULSE_CYCLES(1), .RETRIG(0)) dut10 (.mclk(mclk), .rst(rst), .bus(bus10));

  logic [3:0] q_all, qn_all;
  assign q_all  = {bus10.q,   bus11.q,   bus50.q,   bus51.q};
  assign qn_all = {bus10.q_n, bus11.q_n, bus50.q_n, bus51.q_n};

  always #5 mclk = ~mclk;

  typedef struct {
    bit         do_reset;
    int         upto;
    bit         a_n;
    bit         b;
    bit         clr_n;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] ex(input bit q51, input bit q50, input bit q11, input bit q10);
    return {q10, q11, q50, q51};
  endfunction

  // Advances the reference model by one mclk edge using the pin levels
  // seen at that edge.
  task automatic modelEdge(input logic ia, input logic ib, input logic ic, input logic ir);
    logic trg;
    logic q_prev;
    tick++;
    trg = (prev_a && !ia && ib && ic) ||
          (!prev_b && ib && !ia && ic) ||
          (!prev_c && ic && !ia && ib);
    for (int i = 0; i < 4; i++) begin
      q_prev = (tick <= end_edge[i]);
      if (ir) begin
        end_edge[i] = tick;
      end else if (!ic) begin
        end_edge[i] = tick;
      end else if (trg && (!q_prev || R_TAB[i] != 0 || tick == end_edge[i])) begin
        end_edge[i] = tick + P_TAB[i];
      end
    end
    prev_a = ia;
    prev_b = ib;
    prev_c = ic;
  endtask

  // Drives pins away from the active edge, lets one rising edge pass,
  // then returns 1 time unit later so outputs can be sampled.
  task automatic applyStimulus(input logic ia, input logic ib, input logic ic, input logic ir);
    @(negedge mclk);
    a_n   = ia;
    b     = ib;
    clr_n = ic;
    rst   = ir;
    @(posedge mclk);
    modelEdge(ia, ib, ic, ir);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_q);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_all[i] !== exp_q[i] || qn_all[i] !== ~exp_q[i]) begin
        failures++;
        $display("[TB] FAIL %s inst=%0d edge=%0d got q=%b q_n=%b expected q=%b q_n=%b",
                 name, i, edge_no, q_all[i], qn_all[i], exp_q[i], ~exp_q[i]);
      end
    end
  endtask

  task automatic checkModel();
    logic [3:0] exp_q;
    for (int i = 0; i < 4; i++) exp_q[i] = (tick < end_edge[i]);
    checkOutput("random", exp_q);
  endtask

  task automatic resetScenario(input logic ia, input logic ib, input logic ic);
    applyStimulus(ia, ib, ic, 1'b1);
    edge_no = 0;
    checkOutput("reset", 4'b0000);
  endtask

  initial begin
    logic [3:0] e;
    logic ra, rb, rc, rr;

    // Scenario A: a_n fall at edge 10.
    vecs.push_back('{1, 0,  1, 1, 1, ex(0,0,0,0)});
    vecs.push_back('{0, 9,  1, 1, 1, ex(0,0,0,0)});
    vecs.push_back('{0, 10, 0, 1, 1, ex(1,1,1,1)});
    vecs.push_back('{0, 14, 0, 1, 1, ex(1,1,0,0)});
    vecs.push_back('{0, 16, 0, 1, 1, ex(0,0,0,0)});
    // Scenario B1: b rises at 10 and again at 13 (retrigger window).
    vecs.push_back('{1, 0,  0, 0, 1, ex(0,0,0,0)});
    vecs.push_back('{0, 9,  0, 0, 1, ex(0,0,0,0)});
    vecs.push_back('{0, 10, 0, 1, 1, ex(1,1,1,1)});
    vecs.push_back('{0, 12, 0, 0, 1, ex(1,1,0,0)});
    vecs.push_back('{0, 13, 0, 1, 1, ex(1,1,1,1)});
    vecs.push_back('{0, 14, 0, 1, 1, ex(1,1,0,0)});
    vecs.push_back('{0, 17, 0, 1, 1, ex(1,0,0,0)});
    vecs.push_back('{0, 19, 0, 1, 1, ex(0,0,0,0)});
    // Scenario B2: as B1 plus a third b rise on the 5-cycle expiry edge 15.
    vecs.push_back('{1, 0,  0, 0, 1, ex(0,0,0,0)});
    vecs.push_back('{0, 9,  0, 0, 1, ex(0,0,0,0)});
    vecs.push_back('{0, 10, 0, 1, 1, ex(1,1,1,1)});
    vecs.push_back('{0, 12, 0, 0, 1, ex(1,1,0,0)});
    vecs.push_back('{0, 13, 0, 1, 1, ex(1,1,1,1)});
    vecs.push_back('{0, 14, 0, 0, 1, ex(1,1,0,0)});
    vecs.push_back('{0, 15, 0, 1, 1, ex(1,1,1,1)});
    vecs.push_back('{0, 19, 0, 1, 1, ex(1,1,0,0)});
    vecs.push_back('{0, 20, 0, 1, 1, ex(0,0,0,0)});

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].do_reset) begin
        resetScenario(vecs[k].a_n, vecs[k].b, vecs[k].clr_n);
      end else begin
        while (edge_no < vecs[k].upto) begin
          edge_no++;
          applyStimulus(vecs[k].a_n, vecs[k].b, vecs[k].clr_n, 1'b0);
          checkOutput("table", vecs[k].exp_q);
        end
      end
    end

    // Clear during a pulse at edge 12, then clr_n rising edge trigger at 20.
    resetScenario(1'b1, 1'b1, 1'b1);
    for (int n = 1; n <= 26; n++) begin
      edge_no = n;
      if (n < 10)       applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      else if (n < 12)  applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      else if (n < 20)  applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      else              applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      e[0] = (n inside {[10:11], [20:24]});
      e[1] = e[0];
      e[2] = (n == 10 || n == 20);
      e[3] = e[2];
      checkOutput("clear", e);
    end

    // Reset mid-pulse at edge 12; pins move into a trigger state while
    // reset is held, and no pulse must follow its release.
    resetScenario(1'b1, 1'b1, 1'b1);
    for (int n = 1; n <= 22; n++) begin
      edge_no = n;
      if (n < 10)       applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      else if (n < 12)  applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      else if (n == 12) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      else if (n < 15)  applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      else              applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      e[0] = (n inside {[10:11]});
      e[1] = e[0];
      e[2] = (n == 10);
      e[3] = e[2];
      checkOutput("rst_mid", e);
    end

    // Randomized pins against the reference model.
    resetScenario(1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      edge_no = n + 1;
      ra = 1'($urandom_range(1));
      rb = 1'($urandom_range(1));
      rc = ($urandom_range(7) != 0);
      rr = ($urandom_range(63) == 0);
      applyStimulus(ra, rb, rc, rr);
      checkModel();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sn74123
